// File: rtl/softmax_pair_packer_16_pkg.sv
// Shared softmax definitions: sample width, frame beat limit, pad value and
// the pair-packer state encoding.
package softmax_pair_packer_16_pkg;

  localparam int unsigned SOFTMAX_DATA_SIZE = 16;
  localparam int unsigned SOFTMAX_MAX_PAIRS = 255;

  typedef enum logic {
    LO_EMPTY,
    LO_HELD
  } pair_state_t;

  // Most negative two's complement value of the given width (sign bit only).
  function automatic logic [63:0] pad_value(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/axis_out_reg_16.sv
// Single-entry AXI4-Stream output register; a load may coincide with the
// consumption of the current beat.
module axis_out_reg_16 #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         free_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q,  data_d;
  logic         last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/softmax_pair_packer_16.sv
// Pairs scalar samples into two-lane beats for the softmax core, padding odd
// frames. Define SOFTMAX_PAIR_LEN_CHECK_EN to build the frame overlength check.
module softmax_pair_packer_16
  import softmax_pair_packer_16_pkg::*;
#(
  parameter int unsigned data_size = SOFTMAX_DATA_SIZE,
  parameter int unsigned MAX_PAIRS = SOFTMAX_MAX_PAIRS
) (
  input  logic                   axi_clock_i,
  input  logic                   axi_reset_i,
  input  logic                   s_axis_valid_i,
  input  logic [data_size-1:0]   s_axis_data_i,
  input  logic                   s_axis_last_i,
  output logic                   s_axis_ready_o,
  input  logic                   m_axis_ready_i,
  output logic [2*data_size-1:0] m_axis_data_o,
  output logic                   m_axis_valid_o,
  output logic                   m_axis_last_o,
  output logic                   frame_err_o
);

  localparam logic [data_size-1:0] PAD = data_size'(pad_value(data_size));

  pair_state_t            state_q, state_d;
  logic [data_size-1:0]   lo_q, lo_d;
  logic                   out_free;
  logic                   s_fire;
  logic                   load;
  logic                   beat_last;
  logic [2*data_size-1:0] beat_data;

  always_comb begin
    state_d        = state_q;
    lo_d           = lo_q;
    s_axis_ready_o = out_free;
    load           = 1'b0;
    beat_data      = {PAD, s_axis_data_i};
    if (state_q == LO_EMPTY && !s_axis_last_i) s_axis_ready_o = 1'b1;
    s_fire = s_axis_valid_i && s_axis_ready_o;
    if (state_q == LO_HELD) beat_data = {s_axis_data_i, lo_q};
    if (s_fire) begin
      if (state_q == LO_EMPTY && !s_axis_last_i) begin
        lo_d    = s_axis_data_i;
        state_d = LO_HELD;
      end else begin
        load    = 1'b1;
        state_d = LO_EMPTY;
      end
    end
  end

  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      state_q <= LO_EMPTY;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
    end
  end

`ifdef SOFTMAX_PAIR_LEN_CHECK_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       overlen;

  // An overlong frame is cut by forcing last on the beat that hits the limit.
  always_comb begin
    overlen   = load && !s_axis_last_i && (cnt_q == 8'(MAX_PAIRS - 1));
    beat_last = s_axis_last_i || overlen;
    err_d     = overlen;
    cnt_d     = cnt_q;
    if (load) cnt_d = beat_last ? '0 : cnt_q + 8'd1;
  end

  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign frame_err_o = err_q;
`else
  assign beat_last   = s_axis_last_i;
  assign frame_err_o = 1'b0;
`endif

  axis_out_reg_16 #(
    .W (2 * data_size)
  ) u_out_reg (
    .clk_i   (axi_clock_i),
    .rst_i   (axi_reset_i),
    .load_i  (load),
    .data_i  (beat_data),
    .last_i  (beat_last),
    .ready_i (m_axis_ready_i),
    .valid_o (m_axis_valid_o),
    .data_o  (m_axis_data_o),
    .last_o  (m_axis_last_o),
    .free_o  (out_free)
  );

endmodule

// File: tb/tb_softmax_pair_packer_16.sv
// Scoreboard bench for softmax_pair_packer_16; honours SOFTMAX_PAIR_LEN_CHECK_EN.
module tb_softmax_pair_packer_16;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        frame_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_xfer_cyc = 0;
  int          last_gap = 0;
  int          ready_mode = 1;  // 0 hold low, 1 hold high, 2 random

  beat_t       exp_q[$];
  logic        m_held = 1'b0;
  logic [15:0] m_lo = '0;
  int          m_cnt = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_last = 1'b0;

  softmax_pair_packer_16 dut (
    .axi_clock_i    (clk),
    .axi_reset_i    (rst),
    .s_axis_valid_i (s_valid),
    .s_axis_data_i  (s_data),
    .s_axis_last_i  (s_last),
    .s_axis_ready_o (s_ready),
    .m_axis_ready_i (m_ready),
    .m_axis_data_o  (m_data),
    .m_axis_valid_o (m_valid),
    .m_axis_last_o  (m_last),
    .frame_err_o    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (ready_mode == 0) m_ready = 1'b0;
    else if (ready_mode == 1) m_ready = 1'b1;
    else m_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    b.err  = 1'b0;
`ifdef SOFTMAX_PAIR_LEN_CHECK_EN
    if (!l && m_cnt == 254) begin
      b.last = 1'b1;
      b.err  = 1'b1;
      m_cnt  = 0;
    end else if (l) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
`endif
    exp_q.push_back(b);
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (ok) begin
      if (!m_held) begin
        if (l) push_beat({16'h8000, d}, 1'b1);
        else begin
          m_held = 1'b1;
          m_lo   = d;
        end
      end else begin
        push_beat({d, m_lo}, l);
        m_held = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t e;
    logic  exp_err;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, hold_data);
        check("hold_last", m_last, hold_last);
      end
      exp_err = (m_valid && !prev_stall && exp_q.size() > 0) ? exp_q[0].err : 1'b0;
      check("frame_err", frame_err, exp_err);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", m_data, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", m_last, e.last);
        end
        last_gap      = cyc - last_xfer_cyc;
        last_xfer_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      hold_data  = m_data;
      hold_last  = m_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1;

    // Even frame with an always-ready sink: beats two cycles apart
    for (int i = 1; i <= 4; i++) send(16'(i), i == 4);
    wait_drain();
    check("beat_gap", last_gap, 2);

    // Odd frame and single-sample frame
    send(16'h0010, 1'b0);
    send(16'h0020, 1'b0);
    send(16'h0030, 1'b1);
    send(16'hFFFF, 1'b1);
    wait_drain();

    // Sink stalled with a pending beat and a held sample
    ready_mode = 0;
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_s_ready", s_ready, 0);
      check("stall_m_valid", m_valid, 1);
    end
    @(posedge clk);
    #1;
    ready_mode = 1;
    send(16'h0004, 1'b1);
    wait_drain();

    // Reset while a sample is held
    send(16'h1234, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_held = 1'b0;
    m_cnt  = 0;
    @(negedge clk);
    check("rst2_m_valid", m_valid, 0);
    check("rst2_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b1);
    wait_drain();

    // Random frames against a randomly stalling sink
    ready_mode = 2;
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) send(16'($urandom), k == len - 1);
    end
    ready_mode = 1;
    wait_drain();

    // Long frame: 512 samples without last, then a closing last sample
    for (int i = 0; i < 512; i++) send(16'(i + 16'h0100), 1'b0);
    send(16'h7777, 1'b1);
    wait_drain();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
